// File: rtl/phase_commutator.sv
// Six-step BLDC commutation and PWM sequencer: synchronised halls, duty and brake/enable
// in, registered per-phase high/low requests out (deadtime is added downstream).
module phase_commutator #(
  parameter int PWM_W     = 11,
  parameter int FAULT_CNT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             brake_n,
  input  logic             clr_fault,
  input  logic [PWM_W-1:0] duty,
  input  logic             hallGrn,
  input  logic             hallYlw,
  input  logic             hallBlu,
  output logic             highGrn,
  output logic             lowGrn,
  output logic             highYlw,
  output logic             lowYlw,
  output logic             highBlu,
  output logic             lowBlu,
  output logic             PWM_sync,
  output logic             fault
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_BRAKE = 2'd2, ST_FAULT = 2'd3} state_t;

  localparam logic [1:0] M_FLT = 2'd0;
  localparam logic [1:0] M_PWM = 2'd1;
  localparam logic [1:0] M_LOW = 2'd2;
  localparam logic [7:0] ILL_LIM = 8'(FAULT_CNT);

  // {high, low} request pair for one phase in the given mode
  function automatic logic [1:0] phase_req(input logic [1:0] mode, input logic pwm);
    case (mode)
      M_PWM:   phase_req = {pwm, ~pwm};
      M_LOW:   phase_req = 2'b01;
      default: phase_req = 2'b00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic [PWM_W-1:0] duty_lat_q, duty_lat_d;
  logic [2:0]       sync1_q, sync2_q;
  logic [7:0]       ill_cnt_q, ill_cnt_d, ill_inc_s;
  logic [5:0]       drv_q, drv_d;
  logic             pwm_sync_q, pwm_sync_d;
  logic             fault_q, fault_d;
  logic             pwm_s, illegal_s, ill_hit_s;
  logic [5:0]       modes_s;

  // Next-state, commutation lookup and output decode
  always_comb begin
    cnt_d      = cnt_q + PWM_W'(1);
    duty_lat_d = (&cnt_q) ? duty : duty_lat_q;
    pwm_s      = (cnt_q < duty_lat_q);
    illegal_s  = (sync2_q == 3'b000) || (sync2_q == 3'b111);
    ill_inc_s  = 8'd0;
    if (illegal_s) begin
      ill_inc_s = (ill_cnt_q == 8'hFF) ? ill_cnt_q : ill_cnt_q + 8'd1;
    end else begin
      ill_inc_s = 8'd0;
    end
    ill_hit_s = (ill_inc_s >= ILL_LIM);

    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = brake_n ? ST_RUN : ST_BRAKE;
        else    state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (!en)            state_d = ST_IDLE;
        else if (ill_hit_s) state_d = ST_FAULT;
        else if (!brake_n)  state_d = ST_BRAKE;
        else                state_d = ST_RUN;
      end
      ST_BRAKE: begin
        if (!en)          state_d = ST_IDLE;
        else if (brake_n) state_d = ST_RUN;
        else              state_d = ST_BRAKE;
      end
      ST_FAULT: begin
        if (clr_fault && !en) state_d = ST_IDLE;
        else                  state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase

    // Only clocks spent inside RUN count towards the illegal-hall limit
    if (state_q == ST_RUN && state_d == ST_RUN) ill_cnt_d = ill_inc_s;
    else                                        ill_cnt_d = 8'd0;

    case (sync2_q)
      3'b101:  modes_s = {M_PWM, M_LOW, M_FLT};
      3'b100:  modes_s = {M_PWM, M_FLT, M_LOW};
      3'b110:  modes_s = {M_FLT, M_PWM, M_LOW};
      3'b010:  modes_s = {M_LOW, M_PWM, M_FLT};
      3'b011:  modes_s = {M_LOW, M_FLT, M_PWM};
      3'b001:  modes_s = {M_FLT, M_LOW, M_PWM};
      default: modes_s = {M_FLT, M_FLT, M_FLT};
    endcase

    case (state_d)
      ST_RUN:   drv_d = {phase_req(modes_s[5:4], pwm_s), phase_req(modes_s[3:2], pwm_s),
                         phase_req(modes_s[1:0], pwm_s)};
      ST_BRAKE: drv_d = {1'b0, pwm_s, 1'b0, pwm_s, 1'b0, pwm_s};
      default:  drv_d = 6'b000000;
    endcase

    pwm_sync_d = &cnt_d;
    fault_d    = (state_d == ST_FAULT);
  end

  // State, counters, hall synchroniser and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      duty_lat_q <= '0;
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      ill_cnt_q  <= 8'd0;
      drv_q      <= 6'b000000;
      pwm_sync_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_lat_q <= duty_lat_d;
      sync1_q    <= {hallGrn, hallYlw, hallBlu};
      sync2_q    <= sync1_q;
      ill_cnt_q  <= ill_cnt_d;
      drv_q      <= drv_d;
      pwm_sync_q <= pwm_sync_d;
      fault_q    <= fault_d;
    end
  end

  assign highGrn  = drv_q[5];
  assign lowGrn   = drv_q[4];
  assign highYlw  = drv_q[3];
  assign lowYlw   = drv_q[2];
  assign highBlu  = drv_q[1];
  assign lowBlu   = drv_q[0];
  assign PWM_sync = pwm_sync_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_phase_commutator.sv
// Bench for phase_commutator: cycle model of the commutation rules, fixed vector table,
// hand-written corner sequences and randomized stimulus.
module tb_phase_commutator;
  localparam int W  = 11;
  localparam int N  = 2048;
  localparam int FC = 16;
  localparam int S_IDLE = 10, S_RUN = 20, S_BRAKE = 30, S_FAULT = 40;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, brake_n = 1'b1, clr_fault = 1'b0;
  logic [W-1:0] duty = '0;
  logic hallGrn = 1'b0, hallYlw = 1'b0, hallBlu = 1'b0;
  logic highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_sync, fault;

  phase_commutator #(.PWM_W(W), .FAULT_CNT(FC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .brake_n(brake_n), .clr_fault(clr_fault), .duty(duty),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .highGrn(highGrn), .lowGrn(lowGrn), .highYlw(highYlw), .lowYlw(lowYlw),
    .highBlu(highBlu), .lowBlu(lowBlu), .PWM_sync(PWM_sync), .fault(fault));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int m_cnt, m_dlat, m_st, m_ill;
  logic [2:0] m_s1, m_s2;
  logic [7:0] m_exp;
  int tbl [8][3];  // per hall code: mode of G/Y/B, 0 float, 1 pwm, 2 low

  typedef struct { logic [2:0] h; logic e; logic bn; logic [5:0] exp; } vec_t;
  vec_t vt [12];

  function automatic logic [7:0] dut_vec();
    return {highGrn, lowGrn, highYlw, lowYlw, highBlu, lowBlu, PWM_sync, fault};
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_dlat = 0; m_st = S_IDLE; m_ill = 0;
    m_s1 = 3'b000; m_s2 = 3'b000; m_exp = 8'h00;
  endtask

  task automatic model_step();
    bit pwm, illegal;
    int nst, ill_next, mode;
    logic [5:0] d;
    logic [2:0] h;
    pwm = (m_cnt < m_dlat);
    h = m_s2;
    illegal = (h == 3'b000) || (h == 3'b111);
    nst = m_st;
    ill_next = 0;
    case (m_st)
      S_IDLE:  if (en) nst = brake_n ? S_RUN : S_BRAKE;
      S_RUN: begin
        if (illegal) ill_next = (m_ill < 255) ? m_ill + 1 : 255;
        if (!en) nst = S_IDLE;
        else if (ill_next >= FC) nst = S_FAULT;
        else if (!brake_n) nst = S_BRAKE;
      end
      S_BRAKE: if (!en) nst = S_IDLE; else if (brake_n) nst = S_RUN;
      default: if (clr_fault && !en) nst = S_IDLE;
    endcase
    m_ill = (m_st == S_RUN && nst == S_RUN) ? ill_next : 0;
    m_st = nst;
    d = 6'b000000;
    for (int p = 0; p < 3; p++) begin
      mode = tbl[h][p];
      if (nst == S_RUN) begin
        d[5-2*p] = (mode == 1) ? pwm : 1'b0;
        d[4-2*p] = (mode == 1) ? !pwm : (mode == 2);
      end else if (nst == S_BRAKE) begin
        d[4-2*p] = pwm;
      end
    end
    if (m_cnt == N - 1) begin m_cnt = 0; m_dlat = int'(duty); end
    else m_cnt = m_cnt + 1;
    m_exp = {d, (m_cnt == N - 1), (nst == S_FAULT)};
    m_s2 = m_s1;
    m_s1 = {hallGrn, hallYlw, hallBlu};
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    total++;
    if (dut_vec() !== m_exp) begin
      bad++;
      $display("FAIL model at %0t: got %b, want %b (HlHlHl sync fault)", $time, dut_vec(), m_exp);
    end
    total++;
    if ((highGrn & lowGrn) | (highYlw & lowYlw) | (highBlu & lowBlu)) begin
      bad++;
      $display("FAIL overlap at %0t: got %b, want no phase with both set", $time, dut_vec());
    end
  endtask

  task automatic wait_cnt(input int target);
    int k = 0;
    while (m_cnt != target && k < N + 4) begin tick(); k++; end
    chk("wait_cnt", m_cnt, target);
  endtask

  task automatic set_hall(input logic [2:0] h);
    {hallGrn, hallYlw, hallBlu} = h;
  endtask

  initial begin
    int og, lg, ly, hs, lb;
    int hold, ill_left;
    logic [2:0] legal [6];
    legal = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    for (int i = 0; i < 8; i++) tbl[i] = '{0, 0, 0};
    tbl[5] = '{1, 2, 0}; tbl[4] = '{1, 0, 2}; tbl[6] = '{0, 1, 2};
    tbl[2] = '{2, 1, 0}; tbl[3] = '{2, 0, 1}; tbl[1] = '{0, 2, 1};
    vt[0]  = '{3'b101, 1'b1, 1'b1, 6'b100100};
    vt[1]  = '{3'b100, 1'b1, 1'b1, 6'b100001};
    vt[2]  = '{3'b110, 1'b1, 1'b1, 6'b001001};
    vt[3]  = '{3'b010, 1'b1, 1'b1, 6'b011000};
    vt[4]  = '{3'b011, 1'b1, 1'b1, 6'b010010};
    vt[5]  = '{3'b001, 1'b1, 1'b1, 6'b000110};
    vt[6]  = '{3'b000, 1'b1, 1'b1, 6'b000000};
    vt[7]  = '{3'b111, 1'b1, 1'b1, 6'b000000};
    vt[8]  = '{3'b101, 1'b1, 1'b0, 6'b010101};
    vt[9]  = '{3'b101, 1'b0, 1'b1, 6'b000000};
    vt[10] = '{3'b101, 1'b1, 1'b1, 6'b100100};
    vt[11] = '{3'b011, 1'b1, 1'b1, 6'b010010};

    model_reset();
    set_hall(3'b101);
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(dut_vec()), 0);
    rst_n = 1'b1;

    // Forward drive at 25 % duty on row 101
    en = 1'b1; brake_n = 1'b1; duty = 11'd512;
    repeat (N) tick();
    og = 0; lg = 0; ly = 0; hs = 0;
    repeat (N) begin
      tick();
      og += int'(highGrn); lg += int'(lowGrn); ly += int'(lowYlw);
      hs += int'(highBlu) + int'(lowBlu);
    end
    chk("t1_highGrn_ones", og, 512);
    chk("t1_lowGrn_ones", lg, N - 512);
    chk("t1_lowYlw_ones", ly, N);
    chk("t1_blu_ones", hs, 0);

    // Fixed table at near-full duty: PWM mode reads as high=1, low=0
    duty = 11'd2047;
    wait_cnt(1);
    for (int i = 0; i < 12; i++) begin
      set_hall(vt[i].h); en = vt[i].e; brake_n = vt[i].bn;
      repeat (4) tick();
      chk($sformatf("vec%0d", i), int'(dut_vec() >> 2), int'(vt[i].exp));
    end

    // 15 illegal clocks are tolerated, 16 trip the fault
    set_hall(3'b000); repeat (15) tick();
    set_hall(3'b101); repeat (5) tick();
    chk("ill15_no_fault", int'(fault), 0);
    set_hall(3'b111); repeat (20) tick();
    chk("ill16_fault", int'(fault), 1);
    chk("fault_outputs_off", int'(dut_vec() >> 2), 0);

    // Fault clear is ignored while enabled
    set_hall(3'b101);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0; repeat (3) tick();
    chk("clr_with_en", int'(fault), 1);
    en = 1'b0; tick();
    chk("fault_holds_en0", int'(fault), 1);
    clr_fault = 1'b1; tick(); clr_fault = 1'b0;
    chk("clr_without_en", int'(fault), 0);
    tick();

    // Regenerative brake at 50 % duty
    en = 1'b1; brake_n = 1'b1; duty = 11'd1024;
    wait_cnt(1);
    brake_n = 1'b0;
    og = 0; lg = 0; ly = 0; lb = 0;
    repeat (N) begin
      tick();
      og += int'(highGrn) + int'(highYlw) + int'(highBlu);
      lg += int'(lowGrn); ly += int'(lowYlw); lb += int'(lowBlu);
    end
    chk("brk_highs", og, 0);
    chk("brk_lowGrn", lg, 1024);
    chk("brk_lowYlw", ly, 1024);
    chk("brk_lowBlu", lb, 1024);
    brake_n = 1'b1; tick();
    chk("brk_exit_run", int'(highGrn), 1);

    // Mid-period duty change must not tear the running period
    duty = 11'd512;
    wait_cnt(1);
    wait_cnt(300);
    duty = 11'd100;
    og = 0;
    repeat (N - 300) begin tick(); og += int'(highGrn); end
    chk("duty_old_period", og, 212);
    og = 0;
    repeat (N) begin tick(); og += int'(highGrn); end
    chk("duty_new_period", og, 100);

    // Asynchronous reset between clock edges
    repeat (200) tick();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_now", int'(dut_vec()), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model
    hold = 1; ill_left = 0;
    for (int c = 0; c < 6000; c++) begin
      clr_fault = 1'b0;
      hold--;
      if (hold <= 0) begin
        if ($urandom_range(0, 5) == 0) begin
          set_hall(($urandom_range(0, 1) == 0) ? 3'b000 : 3'b111);
          hold = int'($urandom_range(5, 30));
        end else begin
          set_hall(legal[$urandom_range(0, 5)]);
          hold = int'($urandom_range(1, 40));
        end
      end
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) brake_n = ~brake_n;
      if ($urandom_range(0, 49) == 0) clr_fault = 1'b1;
      if ($urandom_range(0, 399) == 0) duty = W'($urandom_range(0, N - 1));
      if (fault && $urandom_range(0, 29) == 0) en = 1'b0;
      if (!en && $urandom_range(0, 39) == 0) en = 1'b1;
      ill_left = ill_left + 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
